// File: rtl/eth_tx_sched.sv
// Round-robin scheduler that shares one RMII TX frame builder between several frame
// sources. It also enforces the interframe gap and aborts frames when the builder stalls.
module eth_tx_sched #(
    parameter int pNUM_REQ     = 2,
    parameter int pMII_WIDTH   = 2,
    parameter int pIFG_BITS    = 96,
    parameter int pIFG_CNT     = pIFG_BITS >> (pMII_WIDTH >> 1),
    parameter int pTIMEOUT_CNT = 8192
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [pNUM_REQ-1:0]         i_req,
    output logic [pNUM_REQ-1:0]         o_gnt,
    output logic [$clog2(pNUM_REQ)-1:0] o_gnt_idx,
    output logic                        o_tx_start,
    input  logic                        i_tx_done,
    output logic                        o_ifg_active,
    output logic                        o_timeout,
    output logic                        o_busy
);

    localparam int lpIdxW = $clog2(pNUM_REQ);
    localparam int lpCntW = $clog2(pTIMEOUT_CNT) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        IFG    = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [lpCntW-1:0]     cnt_q, cnt_d;
    logic [pNUM_REQ-1:0]   gnt_q, gnt_d;
    logic [lpIdxW-1:0]     idx_q, idx_d;
    logic [lpIdxW-1:0]     ptr_q, ptr_d;
    logic                  start_q, start_d;
    logic                  timeout_q, timeout_d;

    logic                  sel_valid;
    logic [lpIdxW-1:0]     sel_idx;

    // First pass finds a request at or above the pointer; the second pass wraps to the lowest one.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int j = 0; j < pNUM_REQ; j++) begin
            if (!sel_valid && i_req[j] && (j >= int'(ptr_q))) begin
                sel_valid = 1'b1;
                sel_idx   = lpIdxW'(j);
            end
        end
        for (int j = 0; j < pNUM_REQ; j++) begin
            if (!sel_valid && i_req[j]) begin
                sel_valid = 1'b1;
                sel_idx   = lpIdxW'(j);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        start_d   = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d        = ACTIVE;
                    gnt_d          = '0;
                    gnt_d[sel_idx] = 1'b1;
                    idx_d          = sel_idx;
                    start_d        = 1'b1;
                    cnt_d          = '0;
                    ptr_d          = (sel_idx == lpIdxW'(pNUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                end
            end
            ACTIVE: begin
                // A done pulse in the watchdog's final cycle counts as a normal completion.
                if (i_tx_done || (cnt_q == lpCntW'(pTIMEOUT_CNT - 1))) begin
                    state_d   = IFG;
                    gnt_d     = '0;
                    idx_d     = '0;
                    cnt_d     = lpCntW'(pIFG_CNT - 1);
                    timeout_d = !i_tx_done;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IFG: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            start_q   <= start_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_gnt        = gnt_q;
    assign o_gnt_idx    = idx_q;
    assign o_tx_start   = start_q;
    assign o_timeout    = timeout_q;
    assign o_ifg_active = (state_q == IFG);
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: a frame-level model is compared against the outputs every cycle.
// Directed scenarios add literal cycle-exact expectations that pin the model.
module tb_eth_tx_sched;

    localparam int N       = 2;
    localparam int IFG_CNT = 48;
    localparam int TO_CNT  = 8192;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [1:0] iReq = 2'b00;
    logic       iTxDone = 1'b0;
    logic [1:0] oGnt;
    logic [0:0] oGntIdx;
    logic       oTxStart, oIfgActive, oTimeout, oBusy;
    logic [6:0] dutVec;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int failPrints = 0;

    // Model state in frame terms: granted source (-1 = none), frame age, remaining IFG cycles.
    int mGnt = -1;
    int mPtr = 0;
    int mAge = 0;
    int mIfgLeft = 0;
    bit mStart = 1'b0;
    bit mTimeout = 1'b0;

    eth_tx_sched dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .i_req        (iReq),
        .o_gnt        (oGnt),
        .o_gnt_idx    (oGntIdx),
        .o_tx_start   (oTxStart),
        .i_tx_done    (iTxDone),
        .o_ifg_active (oIfgActive),
        .o_timeout    (oTimeout),
        .o_busy       (oBusy)
    );

    assign dutVec = {oGnt, oGntIdx, oTxStart, oIfgActive, oTimeout, oBusy};

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge Clk or posedge Rst);
            if (Rst) begin
                mGnt = -1; mPtr = 0; mAge = 0; mIfgLeft = 0; mStart = 1'b0; mTimeout = 1'b0;
            end else begin
                mStart = 1'b0;
                mTimeout = 1'b0;
                if (mGnt >= 0) begin
                    if (iTxDone || mAge == TO_CNT - 1) begin
                        mTimeout = !iTxDone;
                        mGnt = -1;
                        mIfgLeft = IFG_CNT;
                    end else begin
                        mAge++;
                    end
                end else if (mIfgLeft > 0) begin
                    mIfgLeft--;
                end else if (iReq != 2'b00) begin
                    for (int k = 0; k < N; k++) begin
                        int src;
                        src = (mPtr + k) % N;
                        if (mGnt < 0 && ((iReq >> src) & 2'b01) != 2'b00) mGnt = src;
                    end
                    mPtr = (mGnt + 1) % N;
                    mAge = 0;
                    mStart = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            logic [6:0] expVec;
            @(negedge Clk);
            expVec = {(mGnt >= 0) ? 2'(1 << mGnt) : 2'b00,
                      (mGnt >= 0) ? 1'(mGnt) : 1'b0,
                      mStart, mIfgLeft > 0, mTimeout, (mGnt >= 0) || (mIfgLeft > 0)};
            checks++;
            if (dutVec !== expVec) begin
                errors++;
                if (failPrints < 20) begin
                    failPrints++;
                    $display("[TB] FAIL model cyc=%0d got gnt/idx/start/ifg/to/busy=%b expected %b",
                             cyc, dutVec, expVec);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got %0h expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic waitCycle(input int c);
        while (cyc < c) @(negedge Clk);
    endtask

    task automatic applyStimulus(input int atCyc, input logic [1:0] req);
        waitCycle(atCyc);
        iReq = req;
    endtask

    task automatic pulseDone(input int atCyc);
        waitCycle(atCyc);
        iTxDone = 1'b1;
        @(negedge Clk);
        iTxDone = 1'b0;
    endtask

    task automatic waitStart(input int limit, output int startCyc);
        int n;
        n = 0;
        while (n < limit && oTxStart !== 1'b1) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (oTxStart !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_wait cyc=%0d got o_tx_start=%b expected 1 within %0d cycles",
                     cyc, oTxStart, limit);
        end
        startCyc = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL sim_guard cyc=%0d got no end expected finish", cyc);
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int s;
        logic [1:0] rrGnt [4];
        rrGnt = '{2'b10, 2'b01, 2'b10, 2'b01};

        #1 Rst = 1'b1;
        waitCycle(1);
        checkOutput("reset_outputs", 32'(dutVec), 32'h0);
        waitCycle(2);
        Rst = 1'b0;

        // Single source, cycle-exact timeline
        applyStimulus(10, 2'b01);
        waitCycle(11);
        checkOutput("t1_gnt", 32'(oGnt), 32'h1);
        checkOutput("t1_start", 32'(oTxStart), 32'h1);
        waitCycle(12);
        checkOutput("t1_start_pulse", 32'(oTxStart), 32'h0);
        pulseDone(200);
        checkOutput("t1_gnt_drop", 32'(oGnt), 32'h0);
        checkOutput("t1_ifg_first", 32'(oIfgActive), 32'h1);
        waitCycle(248);
        checkOutput("t1_ifg_last", 32'(oIfgActive), 32'h1);
        waitCycle(249);
        checkOutput("t1_ifg_end", 32'(oIfgActive), 32'h0);
        checkOutput("t1_idle_busy", 32'(oBusy), 32'h0);
        waitCycle(250);
        checkOutput("t1_restart", 32'(oTxStart), 32'h1);

        // Request drop mid-frame, then stray done in IFG and IDLE
        applyStimulus(255, 2'b00);
        waitCycle(270);
        checkOutput("t3_gnt_held", 32'(oGnt), 32'h1);
        pulseDone(300);
        pulseDone(320);
        waitCycle(348);
        checkOutput("t6_ifg_last", 32'(oIfgActive), 32'h1);
        waitCycle(349);
        checkOutput("t6_ifg_end", 32'(oIfgActive), 32'h0);
        pulseDone(360);
        checkOutput("t6_idle_busy", 32'(oBusy), 32'h0);

        // Round-robin; pointer sits at 1 after the last grant to source 0
        applyStimulus(400, 2'b11);
        for (int k = 0; k < 4; k++) begin
            waitStart(200, s);
            checkOutput("t2_rr_gnt", 32'(oGnt), 32'(rrGnt[k]));
            checkOutput("t2_rr_idx", 32'(oGntIdx), 32'(k % 2 == 0 ? 1 : 0));
            if (k == 3) iReq = 2'b00;
            pulseDone(s + 100);
        end
        waitCycle(cyc + 60);

        // Watchdog on source 1
        iReq = 2'b10;
        waitStart(10, s);
        iReq = 2'b00;
        checkOutput("t4_gnt", 32'(oGnt), 32'h2);
        waitCycle(s + TO_CNT - 1);
        checkOutput("t4_no_early_to", 32'(oTimeout), 32'h0);
        waitCycle(s + TO_CNT);
        checkOutput("t4_timeout", 32'(oTimeout), 32'h1);
        checkOutput("t4_gnt_drop", 32'(oGnt), 32'h0);
        waitCycle(s + TO_CNT + 1);
        checkOutput("t4_to_pulse", 32'(oTimeout), 32'h0);
        waitCycle(s + TO_CNT + IFG_CNT - 1);
        checkOutput("t4_ifg_last", 32'(oIfgActive), 32'h1);
        waitCycle(s + TO_CNT + IFG_CNT);
        checkOutput("t4_ifg_end", 32'(oBusy), 32'h0);

        // Asynchronous reset mid-frame
        iReq = 2'b01;
        waitStart(10, s);
        checkOutput("t5_gnt", 32'(oGnt), 32'h1);
        waitCycle(s + 50);
        #2 Rst = 1'b1;
        #1 checkOutput("t5_async_reset", 32'(dutVec), 32'h0);
        @(negedge Clk);
        iReq = 2'b10;
        Rst = 1'b0;
        @(negedge Clk);
        checkOutput("t5_regrant_start", 32'(oTxStart), 32'h1);
        checkOutput("t5_regrant_gnt", 32'(oGnt), 32'h2);
        s = cyc;
        iReq = 2'b11;
        pulseDone(s + 20);
        waitStart(100, s);
        checkOutput("t5_next_src0", 32'(oGnt), 32'h1);
        iReq = 2'b00;
        pulseDone(s + 20);
        waitCycle(s + 80);

        // Done in the watchdog's final cycle wins over timeout
        iReq = 2'b01;
        waitStart(10, s);
        iReq = 2'b00;
        pulseDone(s + TO_CNT - 1);
        checkOutput("t7_done_wins", 32'(oTimeout), 32'h0);
        checkOutput("t7_ifg", 32'(oIfgActive), 32'h1);
        waitCycle(s + TO_CNT + IFG_CNT + 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
